// File: rtl/rs_encoder_seq.sv
`timescale 1ns/1ps
// RS(15,9) systematic encoder over GF(16), poly x^4+x+1.
// One message symbol per cycle through a 6-stage parity LFSR.
module rs_encoder_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] messageIn,
  input  logic        encodeMessage,
  output logic [59:0] codewordOut,
  output logic        codewordValid,
  output logic        encoderBusy
);

  localparam int N    = 15;
  localparam int K    = 9;
  localparam int NPAR = 6;
  localparam int SYM  = 4;

  // g(x) low coefficients g0..g5; the x^6 term is implicit
  localparam logic [NPAR-1:0][SYM-1:0] GEN = {
    4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hC
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [SYM*K-1:0]           msg_q, msg_d;
  logic [NPAR-1:0][SYM-1:0]   par_q, par_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [SYM*N-1:0]           cw_q, cw_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic [SYM-1:0]             sym;
  logic [SYM-1:0]             fb;

  // GF(16) multiply; with a constant k this folds to XOR gates
  function automatic logic [SYM-1:0] gmul(
    input logic [SYM-1:0] a,
    input logic [SYM-1:0] k
  );
    logic [SYM-1:0] p;
    logic [SYM-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < SYM; i++) begin
      if (k[i]) p = p ^ x;
      x = {x[SYM-2:0], 1'b0} ^ (x[SYM-1] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      msg_q   <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      cw_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      cw_q    <= cw_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: capture, shift highest symbol first, publish
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    cw_d    = cw_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    sym     = '0;
    for (int k = 0; k < K; k++) begin
      if (cnt_q == 4'(K - 1 - k)) sym = msg_q[k*SYM +: SYM];
    end
    fb = sym ^ par_q[NPAR-1];
    unique case (state_q)
      IDLE: begin
        if (encodeMessage) begin
          msg_d   = messageIn;
          par_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        par_d[0] = gmul(fb, GEN[0]);
        for (int i = 1; i < NPAR; i++) begin
          par_d[i] = par_q[i-1] ^ gmul(fb, GEN[i]);
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(K - 1)) state_d = DONE;
      end
      DONE: begin
        cw_d    = {msg_q, par_q};
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign codewordOut   = cw_q;
  assign codewordValid = valid_q;
  assign encoderBusy   = busy_q;

endmodule

// File: tb/tb_rs_encoder_seq.sv
`timescale 1ns/1ps
// Directed bench for rs_encoder_seq.
// Hand vectors plus a long-division reference and syndrome check.
module tb_rs_encoder_seq;

  logic        clk;
  logic        rst;
  logic [35:0] messageIn;
  logic        encodeMessage;
  logic [59:0] codewordOut;
  logic        codewordValid;
  logic        encoderBusy;

  int n_cmp;
  int n_bad;

  rs_encoder_seq dut (
    .clk           (clk),
    .rst           (rst),
    .messageIn     (messageIn),
    .encodeMessage (encodeMessage),
    .codewordOut   (codewordOut),
    .codewordValid (codewordValid),
    .encoderBusy   (encoderBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gf_mul(input logic [3:0] a,
                                        input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gen(input int j);
    case (j)
      0: return 4'hC;
      1: return 4'hA;
      2: return 4'hC;
      3: return 4'h3;
      4: return 4'h9;
      5: return 4'h7;
      default: return 4'h1;
    endcase
  endfunction

  // x^6*m(x) mod g(x) by polynomial long division
  function automatic logic [59:0] ref_enc(input logic [35:0] msg);
    logic [3:0]  c [15];
    logic [3:0]  q;
    logic [59:0] res;
    for (int i = 0; i < 15; i++) c[i] = 4'h0;
    for (int k = 0; k < 9; k++) c[k+6] = msg[4*k +: 4];
    for (int d = 14; d >= 6; d--) begin
      q = c[d];
      for (int j = 0; j <= 6; j++)
        c[d-6+j] = c[d-6+j] ^ gf_mul(q, gen(j));
    end
    res = '0;
    res[59:24] = msg;
    for (int i = 0; i < 6; i++) res[4*i +: 4] = c[i];
    return res;
  endfunction

  // Six syndromes S1..S6 packed, S1 in the low nibble
  function automatic logic [23:0] syndromes(input logic [59:0] cw);
    logic [3:0]  aj;
    logic [3:0]  s;
    logic [23:0] out;
    out = '0;
    aj  = 4'h1;
    for (int j = 1; j <= 6; j++) begin
      aj = gf_mul(aj, 4'h2);
      s  = 4'h0;
      for (int i = 14; i >= 0; i--) s = gf_mul(s, aj) ^ cw[4*i +: 4];
      out[4*(j-1) +: 4] = s;
    end
    return out;
  endfunction

  // Stimulus only: start one encode, wait for the pulse
  task automatic run_encode(input  logic [35:0] msg,
                            output logic [59:0] cw,
                            output int          lat,
                            output logic        busy_done,
                            output logic        valid_after);
    @(negedge clk);
    messageIn     = msg;
    encodeMessage = 1'b1;
    @(posedge clk);
    #1;
    encodeMessage = 1'b0;
    lat = 0;
    while (!codewordValid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    cw        = codewordOut;
    busy_done = encoderBusy;
    @(posedge clk);
    #1;
    valid_after = codewordValid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    encodeMessage = 1'b0;
    messageIn = 36'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (codewordOut !== 60'h0) begin
      n_bad++;
      $display("FAIL reset_cw got %h want 0", codewordOut);
    end
    n_cmp++;
    if ({codewordValid, encoderBusy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 00",
               {codewordValid, encoderBusy});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero();
    logic [59:0] cw;
    int          lat;
    logic        bd, va;
    run_encode(36'h0, cw, lat, bd, va);
    n_cmp++;
    if (lat !== 10) begin
      n_bad++;
      $display("FAIL zero_latency got %0d want 10", lat);
    end
    n_cmp++;
    if (cw !== 60'h0) begin
      n_bad++;
      $display("FAIL zero_cw got %h want 0", cw);
    end
    n_cmp++;
    if (bd !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_busy_fall got %b want 0", bd);
    end
    n_cmp++;
    if (va !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_pulse_width got %b want 0", va);
    end
  endtask

  task automatic test_generator();
    logic [59:0] cw;
    int          lat;
    logic        bd, va;
    run_encode(36'h000000001, cw, lat, bd, va);
    n_cmp++;
    if (cw !== 60'h000000001793CAC) begin
      n_bad++;
      $display("FAIL gen_one got %h want 000000001793CAC", cw);
    end
    run_encode(36'h000000002, cw, lat, bd, va);
    n_cmp++;
    if (cw !== 60'h000000002E16B7B) begin
      n_bad++;
      $display("FAIL gen_two got %h want 000000002E16B7B", cw);
    end
    n_cmp++;
    if (lat !== 10) begin
      n_bad++;
      $display("FAIL gen_latency got %0d want 10", lat);
    end
  endtask

  task automatic test_linearity();
    logic [35:0] a, b;
    logic [59:0] ca, cb, cab;
    int          lat;
    logic        bd, va;
    a = 36'h123456789;
    b = 36'hFEDCBA987;
    run_encode(a, ca, lat, bd, va);
    run_encode(b, cb, lat, bd, va);
    run_encode(a ^ b, cab, lat, bd, va);
    n_cmp++;
    if (cab !== (ca ^ cb)) begin
      n_bad++;
      $display("FAIL linearity got %h want %h", cab, ca ^ cb);
    end
    n_cmp++;
    if (ca[59:24] !== a || cb[59:24] !== b) begin
      n_bad++;
      $display("FAIL msg_field got %h/%h want %h/%h",
               ca[59:24], cb[59:24], a, b);
    end
    n_cmp++;
    if (ca !== ref_enc(a)) begin
      n_bad++;
      $display("FAIL ref_a got %h want %h", ca, ref_enc(a));
    end
  endtask

  task automatic test_random();
    logic [35:0] m;
    logic [59:0] cw;
    logic [23:0] syn;
    int          lat;
    logic        bd, va;
    for (int t = 0; t < 24; t++) begin
      m = {$urandom_range(15, 0), $urandom()};
      run_encode(m, cw, lat, bd, va);
      n_cmp++;
      if (cw !== ref_enc(m)) begin
        n_bad++;
        $display("FAIL rand_cw[%0d] got %h want %h", t, cw, ref_enc(m));
      end
      syn = syndromes(cw);
      n_cmp++;
      if (syn !== 24'h0) begin
        n_bad++;
        $display("FAIL rand_syn[%0d] got %h want 0", t, syn);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] m;
    logic [59:0] cw;
    int          pulses;
    int          late_busy;
    m = 36'hA5C3E1F07;
    pulses = 0;
    late_busy = 0;
    cw = '0;
    @(negedge clk);
    messageIn     = m;
    encodeMessage = 1'b1;
    @(posedge clk);
    #1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      encodeMessage = (cyc == 3 || cyc == 10);
      if (cyc == 2) messageIn = 36'h5A5A5A5A5;
      @(posedge clk);
      #1;
      if (codewordValid) begin
        pulses++;
        cw = codewordOut;
      end
      if (cyc > 11 && encoderBusy) late_busy++;
    end
    encodeMessage = 1'b0;
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL b2b_pulses got %0d want 1", pulses);
    end
    n_cmp++;
    if (cw !== ref_enc(m)) begin
      n_bad++;
      $display("FAIL b2b_cw got %h want %h", cw, ref_enc(m));
    end
    n_cmp++;
    if (late_busy !== 0) begin
      n_bad++;
      $display("FAIL b2b_restart got %0d busy cycles want 0", late_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [59:0] cw;
    int          lat;
    int          pulses;
    logic        bd, va;
    pulses = 0;
    @(negedge clk);
    messageIn     = 36'h123456789;
    encodeMessage = 1'b1;
    @(posedge clk);
    #1;
    encodeMessage = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    if (codewordValid) pulses++;
    n_cmp++;
    if ({codewordOut, encoderBusy} !== 61'h0) begin
      n_bad++;
      $display("FAIL midrst_state got cw=%h busy=%b want 0/0",
               codewordOut, encoderBusy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (codewordValid) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL midrst_pulse got %0d want 0", pulses);
    end
    run_encode(36'h000000001, cw, lat, bd, va);
    n_cmp++;
    if (cw !== 60'h000000001793CAC) begin
      n_bad++;
      $display("FAIL midrst_next got %h want 000000001793CAC", cw);
    end
  endtask

  task automatic test_held_start();
    int first;
    int last;
    int pulses;
    int bad_gap;
    first = -1;
    last = -1;
    pulses = 0;
    bad_gap = 0;
    @(negedge clk);
    messageIn     = 36'h000000002;
    encodeMessage = 1'b1;
    for (int e = 0; e <= 34; e++) begin
      @(posedge clk);
      #1;
      if (codewordValid) begin
        pulses++;
        if (first < 0) first = e;
        else if (e - last != 11) bad_gap++;
        last = e;
      end
    end
    @(negedge clk);
    encodeMessage = 1'b0;
    n_cmp++;
    if (pulses !== 3 || first !== 10) begin
      n_bad++;
      $display("FAIL held_pulses got %0d first %0d want 3 first 10",
               pulses, first);
    end
    n_cmp++;
    if (bad_gap !== 0) begin
      n_bad++;
      $display("FAIL held_spacing got %0d bad gaps want 0", bad_gap);
    end
    n_cmp++;
    if (codewordOut !== 60'h000000002E16B7B) begin
      n_bad++;
      $display("FAIL held_cw got %h want 000000002E16B7B", codewordOut);
    end
    repeat (12) @(posedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    encodeMessage = 1'b0;
    messageIn = 36'h0;
    test_reset();
    test_zero();
    test_generator();
    test_linearity();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_held_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_encoder_seq.md
Name: rs_encoder_seq

Overview:
- Systematic RS(15,9) encoder over GF(16), primitive polynomial x^4+x+1 (alpha = 4'b0010).
- Sits directly upstream of the RS(15,9) decoder and produces the 60-bit codeword that the decoder consumes.
- Encoding uses a 6-stage symbol LFSR, clocked one message symbol per cycle, with a start/busy/valid handshake.
- Generator polynomial: g(x) = prod_{i=1..6}(x + alpha^i) = x^6 + 7x^5 + 9x^4 + 3x^3 + Cx^2 + Ax + C (hex coefficients: alpha^10, alpha^14, alpha^4, alpha^6, alpha^9, alpha^6).

Parameters:
- None overridable. Code geometry is fixed to match the decoder: localparams N=15, K=9, NPAR=6, SYM=4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- messageIn  input  36  message; symbol k (k=0..8) = messageIn[4k+:4].
- encodeMessage  input  1  start request; sampled only while encoderBusy=0.
- codewordOut  output  60  codeword; symbol i = codewordOut[4i+:4]. Symbols 6..14 = message symbols 0..8. Symbols 0..5 = parity.
- codewordValid  output  1  one-cycle pulse when codewordOut is updated.
- encoderBusy  output  1  high while an encode is in progress.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; parity regs r0..r5=0; symbol counter=0; codewordOut=0; codewordValid=0; encoderBusy=0. Reset overrides every other input.
- States:
  - IDLE: at an edge with encodeMessage=1, capture messageIn into an internal register, clear r0..r5, set count=0, set encoderBusy=1, go to SHIFT.
  - SHIFT: each edge consumes one symbol, highest degree first. m = captured symbol (8-count), so symbol 8 (messageIn[35:32]) goes first.
    - fb = m ^ r5
    - r5 <= r4 ^ g5*fb; r4 <= r3 ^ g4*fb; r3 <= r2 ^ g3*fb; r2 <= r1 ^ g2*fb; r1 <= r0 ^ g1*fb; r0 <= g0*fb
    - count increments. After the 9th shift (count==8 at the edge) go to DONE.
  - DONE: at the next edge:
    - codewordOut <= {captured message, r5, r4, r3, r2, r1, r0}.
    - codewordValid <= 1 (for exactly one cycle).
    - encoderBusy <= 0; go to IDLE.
- GF multiply by constants is pure XOR logic, with reduction by x^4+x+1. No lookup tables at runtime are required.
- Latency: encodeMessage sampled at edge E0 → codewordValid high in the cycle following edge E10. encoderBusy is high from after E0 through E10 (10 cycles).
- encodeMessage while encoderBusy=1 (including the DONE cycle) is ignored; no queuing. Minimum start-to-start spacing is 11 cycles.
- messageIn is sampled only at the accepting edge. Later changes do not affect the codeword in flight.
- codewordOut holds its last value between completions. codewordValid is 0 except the single completion cycle.
- Reset mid-encode: the encode is aborted, no codewordValid is issued, and codewordOut returns to 0.
- encodeMessage held high continuously re-triggers an encode every 11 cycles.
- All outputs are registered.

Test Plan:
- Reset then messageIn=36'h0, pulse encodeMessage → after 10 cycles codewordValid=1 for 1 cycle, codewordOut=60'h0, encoderBusy falls the same edge.
- messageIn=36'h000000001 → codewordOut=60'h000000001793CAC (equals g(x)).
- Linearity check: encode A=36'h123456789 and B=36'hFEDCBA987 separately, then encode A^B → codewordOut(A^B) == codewordOut(A)^codewordOut(B). Message field equals input in each case.
- Loopback of 500 random messages into the RS(15,9) decoder:
  - error-free codeword → all six syndromes are 0 and the recovered message equals the input;
  - 1 to 3 random symbol errors injected → still recovered.
- Start re-assert at cycles 3 and 10 of a busy period is ignored (single valid pulse). messageIn changed mid-encode does not alter the result.
- rst asserted at shift cycle 5 → no valid pulse, codewordOut=0, encoderBusy=0. The next encode of 36'h000000001 still yields 60'h000000001793CAC.
